// File: rtl/mybusmatrix5x7_in_m0.sv
// AHB bus-matrix input stage: holds a master's address phase while the
// selected output stage is busy or not granting, and relays the data phase back.
module mybusmatrix5x7_in_m0 (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSELS,
    input  logic [31:0] HADDRS,
    input  logic [1:0]  HTRANSS,
    input  logic        HWRITES,
    input  logic [2:0]  HSIZES,
    input  logic [2:0]  HBURSTS,
    input  logic [3:0]  HPROTS,
    input  logic        HMASTLOCKS,
    input  logic        HREADYS,
    input  logic        active_dec,
    input  logic        readyout_dec,
    input  logic [1:0]  resp_dec,
    output logic        sel_op,
    output logic [31:0] addr_op,
    output logic [1:0]  trans_op,
    output logic        write_op,
    output logic [2:0]  size_op,
    output logic [2:0]  burst_op,
    output logic [3:0]  prot_op,
    output logic        mastlock_op,
    output logic        held_tran_op,
    output logic        HREADYOUTS,
    output logic [1:0]  HRESPS
);

    logic        trans_valid;
    logic        capture;
    logic        issue;
    logic        err_first;
    logic        pend_tran;
    logic        pend_next;
    logic        data_valid;
    logic        data_valid_next;

    logic [31:0] hold_addr;
    logic [1:0]  hold_trans;
    logic        hold_write;
    logic [2:0]  hold_size;
    logic [2:0]  hold_burst;
    logic [3:0]  hold_prot;
    logic        hold_mastlock;

    always_comb begin
        trans_valid = HSELS & HTRANSS[1] & HREADYS;
        // A pending transfer owns the holding register until it is issued or dropped.
        capture     = trans_valid & ~pend_tran;
        err_first   = data_valid & (resp_dec == 2'b01) & ~readyout_dec;
    end

    always_comb begin
        sel_op       = HSELS;
        addr_op      = HADDRS;
        trans_op     = HTRANSS;
        write_op     = HWRITES;
        size_op      = HSIZES;
        burst_op     = HBURSTS;
        prot_op      = HPROTS;
        mastlock_op  = HMASTLOCKS;
        held_tran_op = 1'b0;
        if (pend_tran) begin
            sel_op       = 1'b1;
            addr_op      = hold_addr;
            trans_op     = hold_trans;
            write_op     = hold_write;
            size_op      = hold_size;
            burst_op     = hold_burst;
            prot_op      = hold_prot;
            mastlock_op  = hold_mastlock;
            held_tran_op = 1'b1;
        end
    end

    always_comb begin
        issue = sel_op & trans_op[1] & active_dec & readyout_dec;

        pend_next = pend_tran;
        if (pend_tran) begin
            // An ERROR on the previous transfer cancels the held one.
            if (err_first || (active_dec && readyout_dec)) begin
                pend_next = 1'b0;
            end
        end else if (trans_valid && !(active_dec && readyout_dec)) begin
            pend_next = 1'b1;
        end

        data_valid_next = data_valid;
        if (issue) begin
            data_valid_next = 1'b1;
        end else if (readyout_dec) begin
            data_valid_next = 1'b0;
        end
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        HRESPS     = 2'b00;
        if (data_valid) begin
            HREADYOUTS = readyout_dec;
            HRESPS     = resp_dec;
        end else if (pend_tran) begin
            HREADYOUTS = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            pend_tran  <= pend_next;
            data_valid <= data_valid_next;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_addr     <= '0;
            hold_trans    <= '0;
            hold_write    <= 1'b0;
            hold_size     <= '0;
            hold_burst    <= '0;
            hold_prot     <= '0;
            hold_mastlock <= 1'b0;
        end else if (capture) begin
            hold_addr     <= HADDRS;
            hold_trans    <= HTRANSS;
            hold_write    <= HWRITES;
            hold_size     <= HSIZES;
            hold_burst    <= HBURSTS;
            hold_prot     <= HPROTS;
            hold_mastlock <= HMASTLOCKS;
        end
    end

endmodule

// File: tb/tb_mybusmatrix5x7_in_m0.sv
// Directed bench for the bus-matrix input stage; the master sees HREADYOUTS
// as its bus HREADY unless force_rdy overrides it.
module tb_mybusmatrix5x7_in_m0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hready;
    logic        force_rdy;
    logic        active_dec;
    logic        readyout_dec;
    logic [1:0]  resp_dec;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic        mastlock_op;
    logic        held_tran_op;
    logic        hreadyout;
    logic [1:0]  hresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hready = force_rdy ? 1'b1 : hreadyout;

    mybusmatrix5x7_in_m0 dut (
        .HCLK(clk), .HRESETn(rst_n),
        .HSELS(hsel), .HADDRS(haddr), .HTRANSS(htrans), .HWRITES(hwrite),
        .HSIZES(hsize), .HBURSTS(hburst), .HPROTS(hprot), .HMASTLOCKS(hmastlock),
        .HREADYS(hready),
        .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
        .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
        .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op),
        .mastlock_op(mastlock_op), .held_tran_op(held_tran_op),
        .HREADYOUTS(hreadyout), .HRESPS(hresp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic master(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic wr);
        hsel   = sel;
        htrans = tr;
        haddr  = a;
        hwrite = wr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; force_rdy = 1'b0;
        active_dec = 1'b1; readyout_dec = 1'b1; resp_dec = 2'b00;
        hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0;
        master(1'b1, 2'b00, 32'hDEAD_BEEF, 1'b0);
        tick();
        #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout); end
        checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b want 00", hresp); end
        checks++; if (held_tran_op !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", held_tran_op); end
        checks++; if (addr_op !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_addr_live: got %h want deadbeef", addr_op); end
        checks++; if (dut.hold_addr !== 32'h0) begin errors++; $display("FAIL reset_hold_addr: got %h want 0", dut.hold_addr); end
        rst_n = 1'b1;
        master(1'b0, 2'b00, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_pass_through();
        active_dec = 1'b1; readyout_dec = 1'b1;
        master(1'b1, 2'b10, 32'h0000_1000, 1'b0);
        #1;
        checks++; if (addr_op !== 32'h0000_1000) begin errors++; $display("FAIL pass_addr: got %h want 00001000", addr_op); end
        checks++; if (held_tran_op !== 1'b0) begin errors++; $display("FAIL pass_held: got %b want 0", held_tran_op); end
        checks++; if (trans_op !== 2'b10) begin errors++; $display("FAIL pass_trans: got %b want 10", trans_op); end
        tick();
        master(1'b0, 2'b00, 32'h0, 1'b0);
        #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL pass_ready_next: got %b want 1", hreadyout); end
        checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL pass_resp: got %b want 00", hresp); end
        tick();
    endtask

    task automatic test_hold();
        int zero_cycles = 0;
        active_dec = 1'b0; readyout_dec = 1'b1;
        master(1'b1, 2'b10, 32'h0000_2000, 1'b1);
        #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL hold_accept_ready: got %b want 1", hreadyout); end
        tick();
        master(1'b1, 2'b00, 32'hFFFF_0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            active_dec = (c == 2);
            #1;
            if (hreadyout === 1'b0) zero_cycles++;
            checks++; if (held_tran_op !== 1'b1) begin errors++; $display("FAIL hold_held_c%0d: got %b want 1", c, held_tran_op); end
            checks++; if (addr_op !== 32'h0000_2000) begin errors++; $display("FAIL hold_addr_c%0d: got %h want 00002000", c, addr_op); end
            checks++; if (write_op !== 1'b1 || sel_op !== 1'b1 || trans_op !== 2'b10) begin
                errors++; $display("FAIL hold_ctrl_c%0d: got w=%b s=%b t=%b want w=1 s=1 t=10", c, write_op, sel_op, trans_op);
            end
            tick();
        end
        checks++; if (zero_cycles !== 3) begin errors++; $display("FAIL hold_wait_count: got %0d want 3", zero_cycles); end
        #1;
        checks++; if (held_tran_op !== 1'b0) begin errors++; $display("FAIL hold_released: got %b want 0", held_tran_op); end
        checks++; if (addr_op !== 32'hFFFF_0000) begin errors++; $display("FAIL hold_live_after: got %h want ffff0000", addr_op); end
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL hold_data_ready: got %b want 1", hreadyout); end
        master(1'b0, 2'b00, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_wait_states();
        logic exp_rdy [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic rdy_pat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        active_dec = 1'b1; readyout_dec = 1'b1;
        master(1'b1, 2'b10, 32'h0000_3000, 1'b0);
        tick();
        master(1'b0, 2'b00, 32'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            readyout_dec = rdy_pat[c];
            #1;
            checks++; if (hreadyout !== exp_rdy[c]) begin errors++; $display("FAIL wait_ready_c%0d: got %b want %b", c, hreadyout, exp_rdy[c]); end
            checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL wait_resp_c%0d: got %b want 00", c, hresp); end
            tick();
        end
    endtask

    task automatic test_error_pending();
        active_dec = 1'b1; readyout_dec = 1'b1; resp_dec = 2'b00;
        master(1'b1, 2'b10, 32'h0000_4000, 1'b0);
        tick();
        // Second transfer captured while the first is still in its data phase.
        active_dec = 1'b0; readyout_dec = 1'b0; force_rdy = 1'b1;
        master(1'b1, 2'b10, 32'h0000_5000, 1'b1);
        tick();
        force_rdy = 1'b0;
        master(1'b0, 2'b00, 32'h0, 1'b0);
        checks++; if (held_tran_op !== 1'b1) begin errors++; $display("FAIL err_setup_pend: got %b want 1", held_tran_op); end
        active_dec = 1'b1; readyout_dec = 1'b0; resp_dec = 2'b01;
        #1;
        checks++; if (hresp !== 2'b01 || hreadyout !== 1'b0) begin errors++; $display("FAIL err_cycle1: got resp=%b rdy=%b want resp=01 rdy=0", hresp, hreadyout); end
        tick();
        readyout_dec = 1'b1;
        #1;
        checks++; if (hresp !== 2'b01 || hreadyout !== 1'b1) begin errors++; $display("FAIL err_cycle2: got resp=%b rdy=%b want resp=01 rdy=1", hresp, hreadyout); end
        checks++; if (held_tran_op !== 1'b0 || trans_op !== 2'b00) begin errors++; $display("FAIL err_dropped: got held=%b trans=%b want held=0 trans=00", held_tran_op, trans_op); end
        tick();
        resp_dec = 2'b00;
        #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 2'b00) begin errors++; $display("FAIL err_after: got rdy=%b resp=%b want rdy=1 resp=00", hreadyout, hresp); end
        tick();
    endtask

    task automatic test_idle_busy();
        active_dec = 1'b0; readyout_dec = 1'b1;
        master(1'b1, 2'b00, 32'h0000_A000, 1'b0);
        tick();
        master(1'b1, 2'b01, 32'h0000_A004, 1'b0);
        tick();
        #1;
        checks++; if (held_tran_op !== 1'b0 || hreadyout !== 1'b1) begin errors++; $display("FAIL idle_no_capture: got held=%b rdy=%b want held=0 rdy=1", held_tran_op, hreadyout); end
        master(1'b0, 2'b00, 32'h0, 1'b0);
        active_dec = 1'b1;
        tick();
    endtask

    task automatic test_violation();
        active_dec = 1'b0; readyout_dec = 1'b1;
        master(1'b1, 2'b10, 32'h0000_8000, 1'b0);
        tick();
        force_rdy = 1'b1;
        master(1'b1, 2'b10, 32'h0000_9000, 1'b1);
        tick();
        force_rdy = 1'b0;
        master(1'b0, 2'b00, 32'h0, 1'b0);
        #1;
        checks++; if (addr_op !== 32'h0000_8000 || write_op !== 1'b0) begin errors++; $display("FAIL viol_hold_kept: got addr=%h w=%b want 00008000 w=0", addr_op, write_op); end
        active_dec = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (held_tran_op !== 1'b0 || hreadyout !== 1'b1) begin errors++; $display("FAIL viol_cleared: got held=%b rdy=%b want held=0 rdy=1", held_tran_op, hreadyout); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] beat_addr [4] = '{32'h7000, 32'h7004, 32'h7008, 32'h700C};
        logic [1:0]  beat_tr   [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
        logic        act_pat   [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_addr  [4] = '{32'h7000, 32'h7004, 32'h7008, 32'h700C};
        logic [1:0]  exp_tr    [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
        logic [31:0] got_addr [$];
        logic [1:0]  got_tr   [$];
        int idx = 0;
        readyout_dec = 1'b1;
        hburst = 3'b011;
        for (int c = 0; c < 9; c++) begin
            if (idx < 4) master(1'b1, beat_tr[idx], beat_addr[idx], 1'b0);
            else         master(1'b0, 2'b00, 32'h0, 1'b0);
            active_dec = act_pat[c];
            #1;
            if (sel_op && trans_op[1] && active_dec && readyout_dec) begin
                got_addr.push_back(addr_op);
                got_tr.push_back(trans_op);
            end
            if (hready && idx < 4) idx++;
            tick();
        end
        hburst = 3'b000;
        checks++; if (got_addr.size() !== 4) begin errors++; $display("FAIL burst_issue_count: got %0d want 4", got_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_addr.size()) begin
                errors++; $display("FAIL burst_beat%0d: got none want %h/%b", i, exp_addr[i], exp_tr[i]);
            end else if (got_addr[i] !== exp_addr[i] || got_tr[i] !== exp_tr[i]) begin
                errors++; $display("FAIL burst_beat%0d: got %h/%b want %h/%b", i, got_addr[i], got_tr[i], exp_addr[i], exp_tr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        active_dec = 1'b0; readyout_dec = 1'b1;
        master(1'b1, 2'b10, 32'h0000_6000, 1'b1);
        tick();
        master(1'b0, 2'b00, 32'h0000_0040, 1'b0);
        checks++; if (held_tran_op !== 1'b1) begin errors++; $display("FAIL rsthold_setup: got %b want 1", held_tran_op); end
        rst_n = 1'b0;
        tick();
        checks++; if (hreadyout !== 1'b1 || held_tran_op !== 1'b0) begin errors++; $display("FAIL rsthold_outputs: got rdy=%b held=%b want rdy=1 held=0", hreadyout, held_tran_op); end
        checks++; if (dut.hold_addr !== 32'h0) begin errors++; $display("FAIL rsthold_register: got %h want 0", dut.hold_addr); end
        checks++; if (addr_op !== 32'h0000_0040) begin errors++; $display("FAIL rsthold_live: got %h want 00000040", addr_op); end
        rst_n = 1'b1;
        active_dec = 1'b1;
        tick();
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rsthold_no_residual: got %b want 1", hreadyout); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_hold();
        test_wait_states();
        test_error_pending();
        test_idle_busy();
        test_violation();
        test_back_to_back();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
